// File: rtl/morse_round_ctrl.sv
// Morse spy-game round sequencer: stores player 1's code words, then scores
// player 2's guesses word-by-word with an attempt budget and a tick timeout.
module morse_round_ctrl #(
  parameter int SYM_W         = 10,
  parameter int DEPTH         = 16,
  parameter int ADDR_W        = 4,
  parameter int MAX_ATTEMPTS  = 3,
  parameter int TIMEOUT_TICKS = 20
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              tick,
  input  logic              done,
  input  logic              sym_valid,
  input  logic [SYM_W-1:0]  sym_data,
  output logic [1:0]        state,
  output logic [ADDR_W:0]   code_len,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic [ADDR_W-1:0] rd_ptr,
  output logic [SYM_W-1:0]  expected,
  output logic [1:0]        correct,
  output logic [3:0]        attempts_left,
  output logic [ADDR_W:0]   score,
  output logic              timeout,
  output logic              win,
  output logic              game_over
);

  localparam int CNT_W = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [ADDR_W:0]  DEPTH_L   = (ADDR_W + 1)'(DEPTH);
  localparam logic [3:0]       MAX_ATT_L = 4'(MAX_ATTEMPTS);
  localparam logic [CNT_W-1:0] TIMEOUT_L = CNT_W'(TIMEOUT_TICKS);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ENCODE = 2'd1,
    ST_DECODE = 2'd2,
    ST_RESULT = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W:0]   code_len_q, code_len_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [1:0]        correct_q, correct_d;
  logic [3:0]        attempts_left_q, attempts_left_d;
  logic [ADDR_W:0]   score_q, score_d;
  logic              timeout_q, timeout_d;
  logic              win_q, win_d;
  logic [CNT_W-1:0]  tick_cnt_q, tick_cnt_d;

  logic [SYM_W-1:0]  mem [DEPTH];
  logic              mem_we;
  logic [SYM_W-1:0]  mem_rd_word;
  logic              guess_match;
  logic              last_word;

  assign mem_rd_word = mem[rd_ptr_q];
  assign guess_match = (sym_data == mem_rd_word);
  assign last_word   = ({1'b0, rd_ptr_q} == (code_len_q - 1'b1));

  // Code word storage is deliberately left out of reset so it maps to RAM.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[wr_ptr_q] <= sym_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      code_len_q      <= '0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      correct_q       <= '0;
      attempts_left_q <= '0;
      score_q         <= '0;
      timeout_q       <= 1'b0;
      win_q           <= 1'b0;
      tick_cnt_q      <= '0;
    end else begin
      state_q         <= state_d;
      code_len_q      <= code_len_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      correct_q       <= correct_d;
      attempts_left_q <= attempts_left_d;
      score_q         <= score_d;
      timeout_q       <= timeout_d;
      win_q           <= win_d;
      tick_cnt_q      <= tick_cnt_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    code_len_d      = code_len_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    correct_d       = correct_q;
    attempts_left_d = attempts_left_q;
    score_d         = score_q;
    timeout_d       = timeout_q;
    win_d           = win_q;
    tick_cnt_d      = tick_cnt_q;
    mem_we          = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (done) begin
          state_d    = ST_ENCODE;
          wr_ptr_d   = '0;
          rd_ptr_d   = '0;
          code_len_d = '0;
          score_d    = '0;
          correct_d  = '0;
          timeout_d  = 1'b0;
          win_d      = 1'b0;
        end
      end

      ST_ENCODE: begin
        if (sym_valid && (code_len_q != DEPTH_L)) begin
          mem_we     = 1'b1;
          wr_ptr_d   = wr_ptr_q + 1'b1;
          code_len_d = code_len_q + 1'b1;
        end
        // A word arriving with done counts toward the length check.
        if (done && (code_len_d != '0)) begin
          state_d         = ST_DECODE;
          rd_ptr_d        = '0;
          attempts_left_d = MAX_ATT_L;
          tick_cnt_d      = '0;
          correct_d       = '0;
        end
      end

      ST_DECODE: begin
        if (done) begin
          state_d = ST_RESULT;
          win_d   = 1'b0;
        end else if (sym_valid) begin
          if (guess_match) begin
            correct_d       = 2'b01;
            score_d         = score_q + 1'b1;
            attempts_left_d = MAX_ATT_L;
            tick_cnt_d      = '0;
            if (last_word) begin
              state_d = ST_RESULT;
              win_d   = 1'b1;
            end else begin
              rd_ptr_d = rd_ptr_q + 1'b1;
            end
          end else begin
            correct_d = 2'b10;
            if (attempts_left_q == 4'd1) begin
              attempts_left_d = '0;
              state_d         = ST_RESULT;
              win_d           = 1'b0;
            end else begin
              attempts_left_d = attempts_left_q - 1'b1;
            end
          end
        end else if (tick) begin
          tick_cnt_d = tick_cnt_q + 1'b1;
          if (tick_cnt_d == TIMEOUT_L) begin
            state_d   = ST_RESULT;
            timeout_d = 1'b1;
            win_d     = 1'b0;
          end
        end
      end

      ST_RESULT: begin
        if (done) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign state         = state_q;
  assign code_len      = code_len_q;
  assign wr_ptr        = wr_ptr_q;
  assign rd_ptr        = rd_ptr_q;
  assign expected      = (state_q == ST_DECODE) ? mem_rd_word : '0;
  assign correct       = correct_q;
  assign attempts_left = attempts_left_q;
  assign score         = score_q;
  assign timeout       = timeout_q;
  assign win           = win_q;
  assign game_over     = (state_q == ST_RESULT);

endmodule
